// File: rtl/spike_encoder.sv
// Temporal spike encoder. Each channel's value is turned into one pulse per
// gamma wave. The pulse starts value cycles after the wave begins and lasts
// WMAX+1 cycles. Words arrive through a valid/ready handshake into a
// single-entry pending buffer. That buffer becomes the active wave on grst.
module spike_encoder #(
    parameter int CH   = 4,
    parameter int VRES = 3,
    parameter int WRES = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 grst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CH*VRES-1:0]   in_values,
    input  logic [CH-1:0]        in_en,
    output logic [CH-1:0]        spikes,
    output logic                 wave_done
);

    localparam int TMAX = (1 << VRES) - 1;
    localparam int WMAX = (1 << WRES) - 1;
    // The two extra bits let value+WMAX and the done time fit without overflow.
    localparam int TW   = ((VRES > WRES) ? VRES : WRES) + 2;
    localparam logic [TW-1:0] DONE_T = TW'(TMAX + WMAX + 1);
    localparam logic [TW-1:0] WMAX_T = TW'(WMAX);

    logic [CH*VRES-1:0] pend_val;
    logic [CH-1:0]      pend_en;
    logic               pend_full;
    logic [CH*VRES-1:0] act_val;
    logic [CH-1:0]      act_en;
    logic [TW-1:0]      t;
    logic [TW-1:0]      t_next;
    logic               accept;

    assign in_ready = !pend_full;
    assign accept   = in_valid && in_ready;

    // Next wave time: restart on grst, otherwise count up and stick at all-ones.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' and assign a default first, so no latch is inferred.
        t_next = t;
        if (grst) begin
            t_next = '0;
        end else if (t != '1) begin
            t_next = t + 1'b1;
        end
    end

    // Control state: buffer flag, enables, wave counter and done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_full <= 1'b0;
            pend_en   <= '0;
            act_en    <= '0;
            t         <= '1;
            wave_done <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
            t         <= t_next;
            wave_done <= (t_next == DONE_T);
            if (grst) begin
                act_en <= pend_full ? pend_en : '0;
            end
            // Acceptance is only possible when the buffer is empty. A same-edge
            // launch therefore takes the empty buffer and makes a silent wave.
            if (accept) begin
                pend_full <= 1'b1;
                pend_en   <= in_en;
            end else if (grst) begin
                pend_full <= 1'b0;
            end
        end
    end

    // Value payloads. The enables and the full flag gate these values.
    always_ff @(posedge clk) begin
        // NOTE: data registers get no reset; they are never observed until qualified by a reset flag.
        if (accept) begin
            pend_val <= in_values;
        end
        if (grst) begin
            act_val <= pend_val;
        end
    end

    // Spike decode: channel i is high while v <= t <= v+WMAX.
    always_comb begin
        spikes = '0;
        for (int i = 0; i < CH; i++) begin
            spikes[i] = act_en[i]
                && (t >= TW'(act_val[i*VRES +: VRES]))
                && (t <= TW'(act_val[i*VRES +: VRES]) + WMAX_T);
        end
    end

endmodule

// File: tb/tb_spike_encoder.sv
// Self-checking bench for spike_encoder. A cycle-based model tracks the cycle
// of the last wave start, the loaded wave and the pending word. It predicts
// the spikes, in_ready and wave_done values for every cycle.
module tb_spike_encoder;

    localparam int CH   = 4;
    localparam int VRES = 3;
    localparam int WRES = 3;
    localparam int TMAX = (1 << VRES) - 1;
    localparam int WMAX = (1 << WRES) - 1;
    localparam int NEVER = -100000;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 grst;
    logic                 in_valid;
    logic                 in_ready;
    logic [CH*VRES-1:0]   in_values;
    logic [CH-1:0]        in_en;
    logic [CH-1:0]        spikes;
    logic                 wave_done;

    spike_encoder #(.CH(CH), .VRES(VRES), .WRES(WRES)) dut (
        .clk       (clk),
        .rst       (rst),
        .grst      (grst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_values (in_values),
        .in_en     (in_en),
        .spikes    (spikes),
        .wave_done (wave_done)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    // Reference state: wave start cycle, active word and pending word.
    int           last_g = NEVER;
    int           m_val[CH];
    logic [CH-1:0] m_en = '0;
    bit           p_full = 1'b0;
    int           p_val[CH];
    logic [CH-1:0] p_en = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [CH-1:0] exp_spikes();
        int elapsed;
        logic [CH-1:0] s;
        elapsed = cyc - last_g - 1;
        s = '0;
        for (int i = 0; i < CH; i++)
            s[i] = m_en[i] && (elapsed >= m_val[i]) && (elapsed <= m_val[i] + WMAX);
        return s;
    endfunction

    function automatic logic exp_done();
        return (cyc - last_g - 1) == (TMAX + WMAX + 1);
    endfunction

    task automatic model_reset();
        last_g = NEVER;
        m_en   = '0;
        p_full = 1'b0;
        p_en   = '0;
    endtask

    // One clock cycle: drive the inputs, check the outputs, then advance the model at the edge.
    task automatic step(input bit g, input bit v, input logic [CH*VRES-1:0] vals, input logic [CH-1:0] en);
        bit ready;
        @(negedge clk);
        grst      = g;
        in_valid  = v;
        in_values = vals;
        in_en     = en;
        #1;
        check("spikes", 32'(spikes), 32'(exp_spikes()));
        check("in_ready", 32'(in_ready), 32'(!p_full));
        check("wave_done", 32'(wave_done), 32'(exp_done()));
        @(posedge clk);
        ready = !p_full;
        if (g) begin
            last_g = cyc;
            m_en   = p_full ? p_en : '0;
            for (int i = 0; i < CH; i++) m_val[i] = p_val[i];
            p_full = 1'b0;
        end
        if (v && ready) begin
            p_full = 1'b1;
            p_en   = en;
            for (int i = 0; i < CH; i++) p_val[i] = int'(vals[i*VRES +: VRES]);
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, CH*VRES'($urandom), CH'($urandom));
    endtask

    initial begin
        rst = 1'b1; grst = 1'b0; in_valid = 1'b0; in_values = '0; in_en = '0;
        for (int i = 0; i < CH; i++) begin m_val[i] = 0; p_val[i] = 0; end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(3);

        // Basic encode: ch0=3 ch1=0 ch2=7 ch3=5, all enabled.
        step(1'b0, 1'b1, {3'd5, 3'd7, 3'd0, 3'd3}, 4'b1111);
        step(1'b1, 1'b0, '0, '0);
        idle(20);

        // Launch with an empty buffer while a word is offered on the same edge.
        step(1'b1, 1'b1, {3'd1, 3'd1, 3'd1, 3'd1}, 4'b1111);
        idle(18);
        step(1'b1, 1'b0, '0, '0);
        idle(12);

        // Backpressure: A is accepted, B waits until the launch frees the buffer.
        step(1'b0, 1'b1, {3'd6, 3'd2, 3'd4, 3'd1}, 4'b1011);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, {3'd0, 3'd5, 3'd3, 3'd7}, 4'b1110);
        step(1'b1, 1'b1, {3'd0, 3'd5, 3'd3, 3'd7}, 4'b1110);
        step(1'b0, 1'b1, {3'd0, 3'd5, 3'd3, 3'd7}, 4'b1110);
        idle(18);
        step(1'b1, 1'b0, '0, '0);
        idle(18);

        // Truncation: a second launch six cycles in cuts the first wave short.
        step(1'b0, 1'b1, {3'd4, 3'd4, 3'd4, 3'd4}, 4'b1111);
        step(1'b1, 1'b0, '0, '0);
        step(1'b0, 1'b1, {3'd4, 3'd4, 3'd4, 3'd4}, 4'b1111);
        idle(4);
        step(1'b1, 1'b0, '0, '0);
        idle(20);

        // Asynchronous reset mid-wave while ch0 is spiking.
        step(1'b0, 1'b1, {3'd0, 3'd0, 3'd0, 3'd0}, 4'b0001);
        step(1'b1, 1'b1, {3'd2, 3'd2, 3'd2, 3'd2}, 4'b1111);
        idle(2);
        @(negedge clk);
        grst = 1'b0; in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("rst_spikes", 32'(spikes), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_wave_done", 32'(wave_done), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(6);
        step(1'b1, 1'b0, '0, '0);
        idle(18);

        // Enable mask, followed by a long idle stretch in saturation.
        step(1'b0, 1'b1, {3'd2, 3'd2, 3'd2, 3'd2}, 4'b0101);
        step(1'b1, 1'b0, '0, '0);
        idle(80);

        // Back-to-back launches: only zero-valued channels pulse for one cycle.
        step(1'b0, 1'b1, {3'd5, 3'd0, 3'd3, 3'd0}, 4'b1111);
        for (int k = 0; k < 6; k++) step(1'b1, 1'b1, {3'd0, 3'd0, 3'd7, 3'd0}, 4'b1111);
        idle(20);

        // Random traffic.
        for (int k = 0; k < 500; k++)
            step(($urandom_range(0, 11) == 0), 1'($urandom), CH*VRES'($urandom), CH'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/spike_encoder.md
Name: spike_encoder

Overview:
- Temporal (spike-time) encoder feeding neuron/column input synapses.
- Converts a word of CH binary values into one spike per channel per gamma wave; spike time equals the value, counted from the wave start.
- Each spike is a [WMAX+1]-cycle pulse, matching the neuron input pulse format.
- Values arrive through a valid/ready handshake into a single-entry pending buffer; the buffer is launched on each grst pulse.

Parameters:
CH, 4, number of output channels (synapse inputs driven)
VRES, 3, bit resolution of each value; TMAX = 2^VRES-1
WRES, 3, weight resolution of the downstream neuron; WMAX = 2^WRES-1; pulse width = WMAX+1

Ports:
clk  input  1  unit clock for temporal encoding
rst  input  1  reset, asynchronous, active-high
grst  input  1  1-cycle gamma pulse; starts a new wave
in_valid  input  1  value word offered
in_ready  output  1  pending buffer can accept a word
in_values  input  CH*VRES  channel i value in bits [i*VRES +: VRES]
in_en  input  CH  per-channel spike enable; 0 means no spike this wave
spikes  output  CH  encoded spike pulses
wave_done  output  1  1-cycle pulse when the current wave's spike window ends

Behaviour:
- Registers:
  - pend_val/pend_en plus pend_full flag (pending buffer).
  - act_val/act_en (active wave).
  - Wave counter t, width TW = max(VRES,WRES)+2, saturating at all-ones.
- Reset (async, immediate), all outputs deasserted:
  - t = all-ones; act_en = 0; pend_full = 0; pend_en = 0.
  - Resulting outputs: spikes = 0, wave_done = 0, in_ready = 1.
- Handshake:
  - in_ready = !pend_full (combinational from register).
  - Accept when in_valid && in_ready: pend_val <= in_values, pend_en <= in_en, pend_full <= 1.
  - in_values/in_en are ignored when not accepted.
- Wave launch, on a clock edge with grst=1:
  - t <= 0.
  - If pend_full: act_val <= pend_val, act_en <= pend_en, pend_full <= 0.
  - If pend buffer empty: act_en <= 0, giving a silent wave with t still counting.
- grst with simultaneous accept: only possible when the buffer is empty.
  - The launch loads a silent wave.
  - The accepted word lands in pend, waiting for the next grst.
  - No bypass.
- Counting: without grst, t <= t+1 unless t is all-ones (saturate; never wraps, never re-spikes).
- Spike decode: spikes[i] = act_en[i] && (t >= act_val[i]) && (t <= act_val[i]+WMAX).
  - Compare at TW bits, no overflow.
  - Combinational from registers only; no input-to-output path.
- Timing: spike for value v occupies exactly cycles G+1+v .. G+1+v+WMAX, where G is the grst cycle.
- wave_done: registered, high for exactly 1 cycle when t == TMAX+WMAX+1.
  - This is cycle G+1+TMAX+WMAX+1.
  - Asserted regardless of act_en, so silent waves also report done.
- grst mid-wave: t restarts at 0 and act is reloaded next edge.
  - In-flight pulses are truncated by the new wave's decode; no continuation.
  - wave_done is not issued for the truncated wave.
- grst while t saturated (idle): normal launch.
- Back-to-back grst (every cycle): each edge restarts t=0; only channels with value 0 spike (1-cycle pulses).
- Values equal 0 and TMAX are legal; a spike at TMAX ends at t = TMAX+WMAX.

Test Plan:
- Reset: assert rst mid-wave with ch0 high -> spikes=0, in_ready=1, wave_done=0 in the same cycle, before any clk edge; no spike after release until a loaded grst.
- Basic encode (defaults, WMAX=7): accept values {ch0=3, ch1=0, ch2=7, ch3=5}, en=1111, grst at G ->
  - ch1 high G+1..G+8; ch0 G+4..G+11; ch3 G+6..G+13; ch2 G+8..G+15.
  - wave_done only at G+16; in_ready back to 1 at G+1.
- Empty-buffer grst: grst with pend empty while in_valid=1 offers {1,1,1,1} ->
  - that wave silent; wave_done at G+16.
  - Next grst at H emits all channels H+2..H+9.
- Backpressure: offer word A then word B before grst ->
  - A accepted; in_ready=0 and B held until the grst edge.
  - B accepted on the cycle after launch and used on the following wave.
- Truncation: values all 4, second grst at G+6 ->
  - pulses drop at G+7 (t=0 < 4).
  - New wave pulses at G+11..G+18; no wave_done for the first wave.
- Enable mask/saturation: en=0101, values 2 -> only ch0, ch2 high G+3..G+10; with no further grst, t saturates and spikes stay 0 for more than 64 cycles.
